// File: rtl/onehot_dec_pkg.sv
// Shared types and helpers for the one-hot decoder sequencer.
// Holds the FSM state encoding, the gap counter width and a generic index-to-one-hot helper.
package onehot_dec_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } dec_state_t;

    localparam int HOLD_W    = 8;
    localparam int MAX_IN_W  = 8;
    localparam int MAX_OUT_W = 1 << MAX_IN_W;

    // Sized for the widest supported index; callers cast the result down to their OUT_W.
    function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_IN_W-1:0] code);
        return MAX_OUT_W'(1) << code;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a synchronous flush and a separate occupancy counter.
// full/empty come from the counter; pointers are log2(DEPTH) bits and wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 2,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign level = count;
    assign dout  = mem[rd_ptr];
    assign wr_en = push & ~full;
    assign rd_en = pop & ~empty;

    // Storage is cleared on reset too, so dout never carries X into the decoder.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/onehot_dec_seq.sv
// Clocked N-to-2^N decoder: buffers binary indices in a FIFO and presents each as a
// one-hot word under valid/ready, with an optional forced idle gap after every handshake.
module onehot_dec_seq
    import onehot_dec_pkg::*;
#(
    parameter int IN_W     = 3,
    parameter int DEPTH    = 2,
    parameter int HOLD_CYC = 0,
    localparam int OUT_W   = 1 << IN_W,
    localparam int LVL_W   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_code,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out,
    output logic [LVL_W-1:0] fifo_level,
    output dec_state_t       dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // a producer holds valid and its data stable until that edge, and ready never waits on valid.

    dec_state_t        state_q, state_d;
    logic [OUT_W-1:0]  out_q, out_d;
    logic              vld_q, vld_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic              load;
    logic              pop;
    logic              push;
    logic              fifo_full;
    logic              fifo_empty;
    logic [IN_W-1:0]   fifo_dout;

    assign in_ready   = rst_n & en & ~fifo_full;
    assign push       = in_valid & in_ready;
    assign out        = out_q;
    assign out_valid  = vld_q;
    assign dbg_state  = state_q;

    sync_fifo #(
        .WIDTH (IN_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (~en),
        .push  (push),
        .din   (in_code),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        vld_d   = vld_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        pop     = 1'b0;
        if (!en) begin
            state_d = IDLE;
            out_d   = '0;
            vld_d   = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: load = ~fifo_empty;
                SHOW: begin
                    if (out_ready) begin
                        if (HOLD_CYC == 0) begin
                            load = ~fifo_empty;
                            if (fifo_empty) begin
                                out_d   = '0;
                                vld_d   = 1'b0;
                                state_d = IDLE;
                            end
                        end else begin
                            out_d   = '0;
                            vld_d   = 1'b0;
                            cnt_d   = HOLD_W'(HOLD_CYC - 1);
                            state_d = GAP;
                        end
                    end
                end
                // The last gap cycle may already fetch, so the blank window is exactly HOLD_CYC.
                GAP: begin
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                        load    = ~fifo_empty;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (load) begin
                pop     = 1'b1;
                out_d   = OUT_W'(onehot(MAX_IN_W'(fifo_dout)));
                vld_d   = 1'b1;
                state_d = SHOW;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            out_q   <= '0;
            vld_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            vld_q   <= vld_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_onehot_dec_seq.sv
// Bench for onehot_dec_seq: two instances (no gap, gap of 3) driven together and
// checked every cycle against a queue-based model, plus directed literal expectations.
module tb_onehot_dec_seq;
    import onehot_dec_pkg::*;

    localparam int DEPTH = 2;
    localparam int HOLD0 = 0;
    localparam int HOLD1 = 3;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       in_valid   [2];
    logic [2:0] in_code    [2];
    logic       out_ready  [2];
    logic       in_ready   [2];
    logic       out_valid  [2];
    logic [7:0] out_w      [2];
    logic [1:0] fifo_level [2];
    dec_state_t dbg_state  [2];

    // scoreboard / model state
    logic [2:0] exp_q [2][$];
    bit         cur_vld  [2];
    logic [2:0] cur_code [2];
    int         gap_left [2];
    int         n_cmp;
    int         n_bad;

    onehot_dec_seq #(.IN_W(3), .DEPTH(DEPTH), .HOLD_CYC(HOLD0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .en(en),
        .in_valid(in_valid[0]), .in_code(in_code[0]), .in_ready(in_ready[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out(out_w[0]),
        .fifo_level(fifo_level[0]), .dbg_state(dbg_state[0])
    );

    onehot_dec_seq #(.IN_W(3), .DEPTH(DEPTH), .HOLD_CYC(HOLD1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .en(en),
        .in_valid(in_valid[1]), .in_code(in_code[1]), .in_ready(in_ready[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out(out_w[1]),
        .fifo_level(fifo_level[1]), .dbg_state(dbg_state[1])
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int hold_of(input int g);
        return (g == 0) ? HOLD0 : HOLD1;
    endfunction

    task automatic model_clear(input int g);
        exp_q[g].delete();
        cur_vld[g]  = 1'b0;
        cur_code[g] = 3'd0;
        gap_left[g] = 0;
    endtask

    // One rising edge of the model: word leaves on handshake, next word comes from the
    // head of the queue once any blanking window has expired, new index joins the tail.
    task automatic model_step(input int g);
        bit push;
        bit fetch;
        if (!rst_n || !en) begin
            model_clear(g);
            return;
        end
        push  = in_valid[g] && (exp_q[g].size() < DEPTH);
        fetch = 1'b0;
        if (cur_vld[g]) begin
            if (out_ready[g]) begin
                cur_vld[g] = 1'b0;
                if (hold_of(g) > 0) gap_left[g] = hold_of(g);
                else fetch = 1'b1;
            end
        end else begin
            if (gap_left[g] > 0) gap_left[g] = gap_left[g] - 1;
            fetch = (gap_left[g] == 0);
        end
        if (fetch && exp_q[g].size() > 0) begin
            cur_code[g] = exp_q[g].pop_front();
            cur_vld[g]  = 1'b1;
        end
        if (push) exp_q[g].push_back(in_code[g]);
    endtask

    task automatic chk(input string name, input int g, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[inst%0d] t=%0t: got %02h, want %02h", name, g, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        for (int g = 0; g < 2; g++) begin
            chk("out",        g, out_w[g],              cur_vld[g] ? (8'h01 << cur_code[g]) : 8'h00);
            chk("out_valid",  g, 8'(out_valid[g]),      8'(cur_vld[g]));
            chk("in_ready",   g, 8'(in_ready[g]),       8'(rst_n && en && (exp_q[g].size() < DEPTH)));
            chk("fifo_level", g, 8'(fifo_level[g]),     8'(exp_q[g].size()));
        end
    endtask

    // driver: advance one edge, step the model, check outputs 1 time unit later
    task automatic cyc();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        compare_all();
    endtask

    task automatic drv(input bit v, input logic [2:0] c, input bit r);
        for (int g = 0; g < 2; g++) begin
            in_valid[g]  = v;
            in_code[g]   = c;
            out_ready[g] = r;
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        en    = 1'b1;
        drv(1'b1, 3'd4, 1'b0);
        model_clear(0);
        model_clear(1);

        // reset held with in_valid high
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rst_out",   0, out_w[0], 8'h00);
            chk("rst_valid", 0, 8'(out_valid[0]), 8'h00);
            chk("rst_ready", 0, 8'(in_ready[0]), 8'h00);
            chk("rst_level", 0, 8'(fifo_level[0]), 8'h00);
        end
        rst_n = 1'b1;
        drv(1'b0, 3'd0, 1'b1);
        repeat (2) cyc();

        // single word, no bypass
        drv(1'b1, 3'd5, 1'b1);
        cyc();
        chk("t2_nobypass", 0, 8'(out_valid[0]), 8'h00);
        chk("t2_level",    0, 8'(fifo_level[0]), 8'h01);
        drv(1'b0, 3'd0, 1'b1);
        cyc();
        chk("t2_word",  0, out_w[0], 8'h20);
        chk("t2_valid", 0, 8'(out_valid[0]), 8'h01);
        cyc();
        chk("t2_once",  0, 8'(out_valid[0]), 8'h00);
        repeat (6) cyc();

        // streaming 0..7 at one word per cycle
        for (int i = 0; i < 8; i++) begin
            drv(1'b1, 3'(i), 1'b1);
            cyc();
            if (i > 0) chk("t3_stream", 0, out_w[0], 8'h01 << (i - 1));
        end
        drv(1'b0, 3'd0, 1'b1);
        cyc();
        chk("t3_last", 0, out_w[0], 8'h80);
        cyc();
        chk("t3_idle", 0, 8'(out_valid[0]), 8'h00);
        repeat (20) cyc();

        // backpressure with DEPTH=2
        drv(1'b1, 3'd3, 1'b0); cyc();
        drv(1'b1, 3'd6, 1'b0); cyc();
        chk("t4_first", 0, out_w[0], 8'h08);
        drv(1'b1, 3'd1, 1'b0); cyc();
        chk("t4_full_lvl", 0, 8'(fifo_level[0]), 8'h02);
        drv(1'b1, 3'd7, 1'b0);
        chk("t4_noready", 0, 8'(in_ready[0]), 8'h00);
        cyc();
        chk("t4_stall_out", 0, out_w[0], 8'h08);
        chk("t4_stall_rdy", 0, 8'(in_ready[0]), 8'h00);
        drv(1'b1, 3'd7, 1'b1); cyc();
        chk("t4_rel1", 0, out_w[0], 8'h40);
        cyc();
        chk("t4_rel2", 0, out_w[0], 8'h02);
        drv(1'b0, 3'd0, 1'b1); cyc();
        chk("t4_rel3", 0, out_w[0], 8'h80);
        repeat (20) cyc();

        // gap of 3 on instance 1
        drv(1'b1, 3'd2, 1'b1); cyc();
        drv(1'b1, 3'd4, 1'b1); cyc();
        chk("t5_first", 1, out_w[1], 8'h04);
        drv(1'b0, 3'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t5_gap_out", 1, out_w[1], 8'h00);
            chk("t5_gap_vld", 1, 8'(out_valid[1]), 8'h00);
        end
        cyc();
        chk("t5_next", 1, out_w[1], 8'h10);
        repeat (10) cyc();

        // flush mid-stall, then async reset between edges
        drv(1'b1, 3'd1, 1'b0); cyc();
        drv(1'b1, 3'd2, 1'b0); cyc();
        drv(1'b1, 3'd3, 1'b0); cyc();
        chk("t6_queued", 0, 8'(fifo_level[0]), 8'h02);
        drv(1'b0, 3'd0, 1'b0);
        en = 1'b0;
        cyc();
        chk("t6_fl_out",   0, out_w[0], 8'h00);
        chk("t6_fl_vld",   0, 8'(out_valid[0]), 8'h00);
        chk("t6_fl_level", 0, 8'(fifo_level[0]), 8'h00);
        chk("t6_fl_rdy",   0, 8'(in_ready[0]), 8'h00);
        en = 1'b1;
        drv(1'b1, 3'd6, 1'b0); cyc();
        drv(1'b0, 3'd0, 1'b0); cyc();
        chk("t6_pre_rst", 0, out_w[0], 8'h40);
        #2;
        rst_n = 1'b0;
        model_clear(0);
        model_clear(1);
        #1;
        compare_all();
        chk("t6_ar_out", 0, out_w[0], 8'h00);
        chk("t6_ar_vld", 0, 8'(out_valid[0]), 8'h00);
        #1;
        rst_n = 1'b1;
        repeat (2) cyc();

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            for (int g = 0; g < 2; g++) begin
                in_valid[g]  = ($urandom_range(0, 9) < 7);
                in_code[g]   = 3'($urandom_range(0, 7));
                out_ready[g] = ($urandom_range(0, 9) < 6);
            end
            en = ($urandom_range(0, 63) != 0);
            cyc();
        end
        en = 1'b1;
        drv(1'b0, 3'd0, 1'b1);
        repeat (20) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
